// File: rtl/uart_bus_arbiter.sv
// uart_bus_arbiter
//   Round-robin arbiter that lets N_REQ requesters share one buffered-UART
//   register bus. A requester may write one word to the TX FIFO or read one
//   word from the RX FIFO. A requester is only considered when the FIFO it
//   needs can serve it, so a blocked requester never stalls the others.
//   Each transaction runs IDLE -> ISSUE -> WAIT (RSP_LATENCY cycles) -> DONE.
//
// Ports
//   clock, resetn     rising-edge clock, asynchronous active-low reset
//   req               per-requester request
//   req_write         per-requester op (1 = write to TX FIFO, 0 = read RX FIFO)
//   req_data          per-requester write word, slice i = [i*WIDTH +: WIDTH]
//   grant             one-hot bus owner (ISSUE through DONE)
//   done              one-cycle completion pulse to the owner
//   rsp_data          last word read from the RX FIFO
//   tx_space          TX FIFO can accept a word
//   rx_avail          RX FIFO holds a word
//   bus_address       UART register address
//   bus_wr, bus_rd    one-cycle write / read strobes
//   bus_data_out      write word
//   bus_data_in       read word, valid RSP_LATENCY cycles after the strobe
module uart_bus_arbiter #(
   parameter int N_REQ         = 4,
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int RX_ADDRESS    = 1,
   parameter int TX_ADDRESS    = 2,
   parameter int RSP_LATENCY   = 1
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         req_write,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         done,
   output logic [WIDTH-1:0]         rsp_data,
   input  logic                     tx_space,
   input  logic                     rx_avail,
   output logic [ADDRESS_WIDTH-1:0] bus_address,
   output logic                     bus_wr,
   output logic                     bus_rd,
   output logic [WIDTH-1:0]         bus_data_out,
   input  logic [WIDTH-1:0]         bus_data_in
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
   localparam logic [2:0] LAST_WAIT = 3'(RSP_LATENCY - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state_r;
   logic [IW-1:0]    rr_ptr_r;
   logic [IW-1:0]    idx_r;
   logic             op_wr_r;
   logic [2:0]       cnt_r;

   logic [N_REQ-1:0] elig_s;
   logic             found_s;
   logic [IW-1:0]    sel_idx_s;
   logic [IW-1:0]    cand_s;
   logic             sel_wr_s;
   logic [WIDTH-1:0] sel_word_s;

   // A requester is eligible only if the FIFO its operation needs is ready.
   assign elig_s = req & ((req_write & {N_REQ{tx_space}}) |
                          (~req_write & {N_REQ{rx_avail}}));

   // Rotating search: first eligible index at or above rr_ptr, wrapping.
   always_comb begin
      found_s   = 1'b0;
      sel_idx_s = '0;
      cand_s    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = IW'((int'(rr_ptr_r) + k) % N_REQ);
         if (!found_s && elig_s[cand_s]) begin
            found_s   = 1'b1;
            sel_idx_s = cand_s;
         end else begin
            found_s   = found_s;
         end
      end
   end

   assign sel_wr_s   = req_write[sel_idx_s];
   assign sel_word_s = req_data[sel_idx_s*WIDTH +: WIDTH];

   // Transaction FSM; every output is a register updated here.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r      <= IDLE;
         rr_ptr_r     <= '0;
         idx_r        <= '0;
         op_wr_r      <= 1'b0;
         cnt_r        <= 3'd0;
         grant        <= '0;
         done         <= '0;
         rsp_data     <= '0;
         bus_address  <= '0;
         bus_wr       <= 1'b0;
         bus_rd       <= 1'b0;
         bus_data_out <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= '0;
               if (found_s) begin
                  // Latch the winner; its request lines are ignored from here on.
                  idx_r        <= sel_idx_s;
                  op_wr_r      <= sel_wr_s;
                  grant        <= ONE_HOT0 << sel_idx_s;
                  bus_address  <= sel_wr_s ? ADDRESS_WIDTH'(TX_ADDRESS)
                                           : ADDRESS_WIDTH'(RX_ADDRESS);
                  bus_wr       <= sel_wr_s;
                  bus_rd       <= ~sel_wr_s;
                  bus_data_out <= sel_wr_s ? sel_word_s : '0;
                  state_r      <= ISSUE;
               end else begin
                  grant        <= '0;
                  bus_address  <= '0;
                  bus_wr       <= 1'b0;
                  bus_rd       <= 1'b0;
                  bus_data_out <= '0;
                  state_r      <= IDLE;
               end
            end
            ISSUE: begin
               bus_wr  <= 1'b0;
               bus_rd  <= 1'b0;
               cnt_r   <= 3'd0;
               state_r <= WAIT;
            end
            WAIT: begin
               if (cnt_r == LAST_WAIT) begin
                  cnt_r   <= 3'd0;
                  done    <= ONE_HOT0 << idx_r;
                  // Read word is captured on the last WAIT cycle; writes leave it alone.
                  if (!op_wr_r) begin
                     rsp_data <= bus_data_in;
                  end else begin
                     rsp_data <= rsp_data;
                  end
                  state_r <= DONE;
               end else begin
                  cnt_r   <= cnt_r + 3'd1;
                  state_r <= WAIT;
               end
            end
            DONE: begin
               done         <= '0;
               grant        <= '0;
               bus_address  <= '0;
               bus_data_out <= '0;
               rr_ptr_r     <= (idx_r == LAST_IDX) ? '0 : idx_r + IW'(1);
               state_r      <= IDLE;
            end
            default: begin
               done         <= '0;
               grant        <= '0;
               bus_address  <= '0;
               bus_wr       <= 1'b0;
               bus_rd       <= 1'b0;
               bus_data_out <= '0;
               cnt_r        <= 3'd0;
               state_r      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter (default parameters).
// Expected transactions are queued when stimulus is applied; a per-cycle
// monitor (tick) compares strobes, done pulses and idle/wait outputs.
module tb_uart_bus_arbiter;

   localparam int LAT = 1;
   localparam logic [31:0] TXA = 32'd2;
   localparam logic [31:0] RXA = 32'd1;

   logic        clock;
   logic        resetn;
   logic [3:0]  req;
   logic [3:0]  req_write;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [7:0]  rsp_data;
   logic        tx_space;
   logic        rx_avail;
   logic [3:0]  bus_address;
   logic        bus_wr;
   logic        bus_rd;
   logic [7:0]  bus_data_out;
   logic [7:0]  bus_data_in;

   uart_bus_arbiter #(
      .N_REQ(4), .WIDTH(8), .ADDRESS_WIDTH(4),
      .RX_ADDRESS(1), .TX_ADDRESS(2), .RSP_LATENCY(LAT)
   ) dut (
      .clock(clock), .resetn(resetn), .req(req), .req_write(req_write),
      .req_data(req_data), .grant(grant), .done(done), .rsp_data(rsp_data),
      .tx_space(tx_space), .rx_avail(rx_avail), .bus_address(bus_address),
      .bus_wr(bus_wr), .bus_rd(bus_rd), .bus_data_out(bus_data_out),
      .bus_data_in(bus_data_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int         idx;
      bit         wr;
      logic [7:0] data;
   } exp_t;

   typedef struct {
      logic [3:0] rq;
      logic [3:0] wr;
      logic       tx;
      logic       rx;
      int         idx;   // -1: nobody eligible
      logic [7:0] word;
   } vec_t;

   exp_t       exp_q[$];
   vec_t       vecs[8];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         ndone = 0;
   int         strobe_cyc = 0;
   int         last_strobe = -1;
   bit         inflight = 1'b0;
   bit         b2b = 1'b0;
   logic [7:0] last_rsp = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_ev(input string name);
      checks++;
      errors++;
      $display("FAIL %s: observed at cycle %0d", name, cyc);
   endtask

   function automatic logic [31:0] put_word(input int idx, input logic [7:0] w);
      logic [31:0] d;
      d = 32'hDEADBEEF;
      if (idx >= 0) d[idx*8 +: 8] = w;
      return d;
   endfunction

   // One clock: advance to the falling edge and check what the DUT shows.
   task automatic tick();
      exp_t e;
      @(negedge clock);
      cyc++;
      if (bus_wr && bus_rd) fail_ev("both_strobes");
      if (bus_wr || bus_rd) begin
         if (inflight || exp_q.size() == 0) begin
            fail_ev("unexpected_strobe");
         end else begin
            e = exp_q[0];
            chk("strobe_op", 32'(bus_wr), 32'(e.wr));
            chk("strobe_grant", 32'(grant), 32'(1) << e.idx);
            chk("strobe_addr", 32'(bus_address), e.wr ? TXA : RXA);
            if (e.wr) chk("strobe_wdata", 32'(bus_data_out), 32'(e.data));
            else bus_data_in = e.data;
            if (b2b && last_strobe >= 0) chk("b2b_period", cyc - last_strobe, 3 + LAT);
            last_strobe = cyc;
            strobe_cyc  = cyc;
            inflight    = 1'b1;
         end
      end else if (done != 4'b0000) begin
         if (!inflight || exp_q.size() == 0) begin
            fail_ev("unexpected_done");
         end else begin
            e = exp_q.pop_front();
            chk("done_onehot", 32'(done), 32'(1) << e.idx);
            chk("done_latency", cyc - strobe_cyc, LAT + 1);
            chk("done_grant", 32'(grant), 32'(1) << e.idx);
            if (!e.wr) begin
               chk("rsp_data", 32'(rsp_data), 32'(e.data));
               last_rsp = e.data;
            end
            bus_data_in = 8'h11;
            inflight    = 1'b0;
            ndone++;
         end
      end else if (inflight) begin
         e = exp_q[0];
         chk("wait_grant", 32'(grant), 32'(1) << e.idx);
         chk("wait_addr", 32'(bus_address), e.wr ? TXA : RXA);
         if (e.wr) chk("wait_wdata", 32'(bus_data_out), 32'(e.data));
      end else begin
         chk("idle_grant", 32'(grant), 32'd0);
         chk("idle_addr", 32'(bus_address), 32'd0);
         chk("idle_wdata", 32'(bus_data_out), 32'd0);
         chk("idle_rsp_hold", 32'(rsp_data), 32'(last_rsp));
      end
   endtask

   // Run until n more transactions complete, then release all requests.
   task automatic serve(input int n, input int maxc, input bit drop_on_strobe);
      int target;
      int k;
      target = ndone + n;
      k = 0;
      while (ndone < target && k < maxc) begin
         tick();
         k++;
         if (drop_on_strobe && inflight) req = 4'b0000;
      end
      req = 4'b0000;
      if (ndone < target) begin
         fail_ev("serve_timeout");
         exp_q.delete();
         inflight = 1'b0;
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      repeat (4) tick();
   endtask

   task automatic wait_strobe(input int maxc);
      int k;
      k = 0;
      while (!inflight && k < maxc) begin
         tick();
         k++;
      end
      if (!inflight) fail_ev("strobe_timeout");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_bus_wr"}, 32'(bus_wr), 32'd0);
      chk({tag, "_bus_rd"}, 32'(bus_rd), 32'd0);
      chk({tag, "_addr"}, 32'(bus_address), 32'd0);
      chk({tag, "_wdata"}, 32'(bus_data_out), 32'd0);
      chk({tag, "_rsp"}, 32'(rsp_data), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //             req      wr       tx    rx    idx word
      vecs[0] = '{4'b0100, 4'b0100, 1'b1, 1'b0,  2, 8'h5A};  // single write
      vecs[1] = '{4'b0010, 4'b0000, 1'b0, 1'b1,  1, 8'hC3};  // single read
      vecs[2] = '{4'b0001, 4'b0001, 1'b1, 1'b0,  0, 8'hFF};
      vecs[3] = '{4'b1000, 4'b0000, 1'b0, 1'b1,  3, 8'h00};
      vecs[4] = '{4'b0010, 4'b0010, 1'b1, 1'b1,  1, 8'hA5};
      vecs[5] = '{4'b0001, 4'b0001, 1'b0, 1'b1, -1, 8'h00};  // write, TX full
      vecs[6] = '{4'b1000, 4'b0000, 1'b1, 1'b0, -1, 8'h00};  // read, RX empty
      vecs[7] = '{4'b0001, 4'b0000, 1'b0, 1'b1,  0, 8'h3C};

      resetn = 1'b1; req = 4'b0000; req_write = 4'b0000; req_data = 32'h0;
      tx_space = 1'b0; rx_avail = 1'b0; bus_data_in = 8'h11;
      #2 resetn = 1'b0;
      #1 check_reset_outputs("reset");
      tick();
      tick();
      resetn = 1'b1;
      tick();

      // Table of single transactions and blocked requests.
      for (int v = 0; v < 8; v++) begin
         req       = vecs[v].rq;
         req_write = vecs[v].wr;
         tx_space  = vecs[v].tx;
         rx_avail  = vecs[v].rx;
         req_data  = put_word(vecs[v].idx, vecs[v].word);
         if (vecs[v].idx >= 0) begin
            exp_q.push_back('{vecs[v].idx, vecs[v].wr[vecs[v].idx], vecs[v].word});
            serve(1, 20, 1'b1);
         end else begin
            repeat (6) tick();
            req = 4'b0000;
            tick();
         end
      end

      // Round-robin from a fresh reset: 0,1,2,3,0 back to back.
      resetn = 1'b0;
      #1 check_reset_outputs("rr_reset");
      last_rsp = 8'h00;
      tick();
      resetn = 1'b1;
      req = 4'b1111; req_write = 4'b1111; tx_space = 1'b1; rx_avail = 1'b0;
      req_data = 32'h44332211;
      exp_q.push_back('{0, 1'b1, 8'h11});
      exp_q.push_back('{1, 1'b1, 8'h22});
      exp_q.push_back('{2, 1'b1, 8'h33});
      exp_q.push_back('{3, 1'b1, 8'h44});
      exp_q.push_back('{0, 1'b1, 8'h11});
      b2b = 1'b1;
      last_strobe = -1;
      serve(5, 40, 1'b0);
      b2b = 1'b0;

      // Eligibility skip: blocked reader 0 must not stall writer 1.
      req = 4'b0011; req_write = 4'b0010; tx_space = 1'b1; rx_avail = 1'b0;
      req_data = put_word(1, 8'h77);
      exp_q.push_back('{1, 1'b1, 8'h77});
      serve(1, 20, 1'b1);
      req = 4'b0001; req_write = 4'b0000;
      repeat (5) tick();
      rx_avail = 1'b1;
      exp_q.push_back('{0, 1'b0, 8'h9E});
      serve(1, 20, 1'b1);

      // Request dropped during WAIT: still completes, one strobe only.
      req = 4'b0100; req_write = 4'b0100; tx_space = 1'b1; rx_avail = 1'b0;
      req_data = put_word(2, 8'h3C);
      exp_q.push_back('{2, 1'b1, 8'h3C});
      wait_strobe(10);
      tick();
      req = 4'b0000;
      serve(1, 10, 1'b0);

      // Reset during WAIT of a read; rr_ptr must restart at 0.
      req = 4'b0010; req_write = 4'b0000; rx_avail = 1'b1; tx_space = 1'b0;
      exp_q.push_back('{1, 1'b0, 8'h55});
      wait_strobe(10);
      tick();
      resetn = 1'b0;
      #1 check_reset_outputs("mid_reset");
      exp_q.delete();
      inflight = 1'b0;
      last_rsp = 8'h00;
      req = 4'b0000;
      tick();
      tick();
      req = 4'b1001; req_write = 4'b1001; tx_space = 1'b1; rx_avail = 1'b0;
      req_data = 32'h13000010;
      exp_q.push_back('{0, 1'b1, 8'h10});
      exp_q.push_back('{3, 1'b1, 8'h13});
      resetn = 1'b1;
      serve(2, 30, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_bus_arbiter.md
UART_BUS_ARBITER -- requirements
Module: uart_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, meaning UART word width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 4, meaning bus address width.
REQ-004 SHALL have parameter RX_ADDRESS, default 1, meaning address of the receive FIFO.
REQ-005 SHALL have parameter TX_ADDRESS, default 2, meaning address of the transmit FIFO.
REQ-006 SHALL have parameter RSP_LATENCY, default 1, meaning cycles from strobe to valid bus_data_in (1..4).
REQ-007 SHALL have ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request.
- req_write  in  N_REQ  per-requester op: 1 = write word to TX FIFO, 0 = read word from RX FIFO.
- req_data  in  N_REQ*WIDTH  per-requester write word; slice i = bits [i*WIDTH +: WIDTH].
- grant  out  N_REQ  one-hot owner of the bus.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- rsp_data  out  WIDTH  word read from the RX FIFO, valid while done is high for a read.
- tx_space  in  1  TX FIFO can accept a word.
- rx_avail  in  1  RX FIFO holds a word.
- bus_address  out  ADDRESS_WIDTH  address presented to the buffered UART.
- bus_wr  out  1  one-cycle write strobe.
- bus_rd  out  1  one-cycle read strobe.
- bus_data_out  out  WIDTH  write word.
- bus_data_in  in  WIDTH  read word.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-009 SHALL treat requester i as eligible in IDLE when req[i]=1 and either (req_write[i]=1 and tx_space=1) or (req_write[i]=0 and rx_avail=1).
REQ-010 SHALL, in IDLE with at least one eligible requester, select the first eligible index found searching upward from rr_ptr modulo N_REQ; SHALL latch index, op and data; SHALL go to ISSUE on the next edge.
REQ-011 SHALL stay in IDLE with all outputs at zero when no requester is eligible; ineligible requesters SHALL be skipped and never block others.
REQ-012 SHALL hold grant one-hot at the latched index from ISSUE through DONE inclusive, and zero in IDLE.
REQ-013 SHALL, in ISSUE, drive bus_address (TX_ADDRESS for a write, RX_ADDRESS for a read) and assert exactly one of bus_wr or bus_rd for exactly one cycle; for a write, SHALL drive bus_data_out with the latched word.
REQ-014 SHALL hold bus_address and bus_data_out stable from ISSUE through DONE, and drive both to zero in IDLE.
REQ-015 SHALL remain in WAIT for RSP_LATENCY cycles using a counter, then go to DONE.
REQ-016 SHALL, in DONE, pulse done[index] for one cycle; for a read, rsp_data SHALL equal bus_data_in sampled on the last WAIT cycle.
REQ-017 SHALL hold rsp_data until the next read completes; writes SHALL NOT modify it.
REQ-018 SHALL, leaving DONE, set rr_ptr to (index+1) mod N_REQ and return to IDLE; back-to-back transactions SHALL take 2+RSP_LATENCY+1 cycles each.
REQ-019 SHALL complete a latched transaction even if req, req_write, req_data, tx_space or rx_avail change after IDLE; done SHALL still pulse.
REQ-020 SHALL ignore req_write and req_data of non-selected requesters at all times.

Reset
REQ-021 SHALL, on resetn low, asynchronously force: state IDLE; grant, done, bus_wr, bus_rd, bus_address, bus_data_out, rsp_data all zero; rr_ptr 0; WAIT counter 0.
REQ-022 SHALL abandon any in-flight transaction on reset, with no done pulse and no further strobe after release.
REQ-023 SHALL resume arbitration from requester 0 on the first edge after resetn rises.

Verification
REQ-024 SHALL cover a single write: req[2]=1, req_write[2]=1, data 0x5A, tx_space=1 -> grant=0b0100, then one bus_wr with address TX_ADDRESS and bus_data_out=0x5A, then done[2] pulses after RSP_LATENCY+1 more cycles.
REQ-025 SHALL cover a single read: req[1]=1, read, rx_avail=1, bus_data_in=0xC3 -> exactly one bus_rd at RX_ADDRESS, then done[1] with rsp_data=0xC3.
REQ-026 SHALL cover round-robin: all four requesters hold write requests, tx_space=1 -> grant order 0,1,2,3,0, with each done pulsing once per grant.
REQ-027 SHALL cover eligibility skip: req[0] reads with rx_avail=0 and req[1] writes with tx_space=1 -> requester 1 is served and requester 0 waits; raising rx_avail then serves requester 0.
REQ-028 SHALL cover reset mid-transaction: assert resetn low during WAIT -> all outputs zero immediately, no done pulse; after release with req[3] held, requester 0 is searched first and requester 3 is then granted.
REQ-029 SHALL cover request drop: req deasserts during WAIT -> transaction completes, done pulses once, no second strobe.
